// File: rtl/adder_8b_rtl.sv
// ---------------------------------------------------------------------------
// adder_8b_rtl
//
// Purpose:
//   Combinational 8-bit unsigned ripple-carry adder with carry-in and
//   carry-out. It is the arithmetic datapath primitive of the function
//   calculator and computes {cout, sum} = in0 + in1 + cin with zero latency.
//   The block holds no state.
//
// Structure:
//   adder_8b_fa       : 1-bit full-adder cell (continuous-assign gates)
//   adder_8b_ripple4  : four full-adder cells chained into a 4-bit stage
//   adder_8b_rtl      : two 4-bit stages (bits 3:0, then bits 7:4)
//
// Ports (adder_8b_rtl):
//   clk    in   1  system clock; present for uniform integration, unused
//   reset  in   1  synchronous active-high reset; no effect (stateless)
//   in0    in   8  unsigned addend A
//   in1    in   8  unsigned addend B
//   cin    in   1  carry-in, weight 1
//   sum    out  8  low 8 bits of in0 + in1 + cin
//   cout   out  1  carry-out (bit 8) of in0 + in1 + cin
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// adder_8b_fa : single full-adder cell
//   a, b  in  1  operand bits
//   c     in  1  carry-in
//   s     out 1  sum bit
//   co    out 1  carry-out (majority of a, b, c)
// ---------------------------------------------------------------------------
module adder_8b_fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);

endmodule

// ---------------------------------------------------------------------------
// adder_8b_ripple4 : 4-bit ripple-carry stage
//   a, b  in  4  operand nibbles
//   ci    in  1  carry into bit 0 of the stage
//   s     out 4  sum nibble
//   co    out 1  carry out of bit 3 of the stage
// ---------------------------------------------------------------------------
module adder_8b_ripple4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  // carry[i] is the carry into bit i; carry[4] leaves the stage.
  logic [4:0] carry;

  assign carry[0] = ci;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cell
      adder_8b_fa u_fa (
        .a  (a[gi]),
        .b  (b[gi]),
        .c  (carry[gi]),
        .s  (s[gi]),
        .co (carry[gi+1])
      );
    end
  endgenerate

  assign co = carry[4];

endmodule

// ---------------------------------------------------------------------------
// adder_8b_rtl : top level, two chained 4-bit ripple stages
// ---------------------------------------------------------------------------
module adder_8b_rtl (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  // stage_carry[k] is the carry into stage k; stage_carry[2] is the final
  // carry-out. The critical path runs cin -> 8 carry cells -> cout.
  logic [2:0] stage_carry;

  assign stage_carry[0] = cin;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_stage
      adder_8b_ripple4 u_stage (
        .a  (in0[gi*4 +: 4]),
        .b  (in1[gi*4 +: 4]),
        .ci (stage_carry[gi]),
        .s  (sum[gi*4 +: 4]),
        .co (stage_carry[gi+1])
      );
    end
  endgenerate

  assign cout = stage_carry[2];

  // Clock and reset exist only so this block drops into the calculator like
  // its clocked neighbours; the datapath is purely combinational.
  logic unused_clk_reset;
  assign unused_clk_reset = &{1'b0, clk, reset};

endmodule

// File: tb/tb_adder_8b_rtl.sv
// ---------------------------------------------------------------------------
// tb_adder_8b_rtl
//
// Purpose:
//   Self-checking bench for adder_8b_rtl. Inputs are driven 1 unit after the
//   rising edge and outputs sampled 1 unit before the next rising edge
//   (10-unit clock period). Each scenario lives in its own task and does its
//   own comparisons; one summary line is printed at the end.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_adder_8b_rtl;

  logic       clk;
  logic       reset;
  logic [7:0] in0;
  logic [7:0] in1;
  logic       cin;
  logic [7:0] sum;
  logic       cout;

  int checks;
  int failures;

  adder_8b_rtl dut (
    .clk   (clk),
    .reset (reset),
    .in0   (in0),
    .in1   (in1),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a vector 1 unit after the next rising edge and return 1 unit
  // before the following rising edge, ready for sampling.
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(posedge clk);
    #1;
    in0 = a;
    in1 = b;
    cin = c;
    #8;
  endtask

  // Reset asserted: outputs must still follow the inputs (0+0+0 here).
  task automatic test_reset();
    reset = 1'b1;
    drive(8'h00, 8'h00, 1'b0);
    checks++;
    if (cout !== 1'b0) begin
      failures++;
      $display("FAIL reset_cout got=%b expected=%b", cout, 1'b0);
    end
    checks++;
    if (sum !== 8'h00) begin
      failures++;
      $display("FAIL reset_sum got=%h expected=%h", sum, 8'h00);
    end
    $display("reset      : %h + %h + %b -> cout=%b sum=%h", in0, in1, cin, cout, sum);
    reset = 1'b0;
  endtask

  // Directed vectors with hand-computed results: basic, wrap, max, nibble.
  task automatic test_directed();
    logic [7:0] va   [7];
    logic [7:0] vb   [7];
    logic       vc   [7];
    logic [7:0] esum [7];
    logic       ecout[7];
    string      name [7];
    va[0]=8'h00; vb[0]=8'h00; vc[0]=1'b0; esum[0]=8'h00; ecout[0]=1'b0; name[0]="zero";
    va[1]=8'h01; vb[1]=8'h01; vc[1]=1'b0; esum[1]=8'h02; ecout[1]=1'b0; name[1]="one_one";
    va[2]=8'h01; vb[2]=8'h01; vc[2]=1'b1; esum[2]=8'h03; ecout[2]=1'b0; name[2]="cin_path";
    va[3]=8'hFF; vb[3]=8'h01; vc[3]=1'b0; esum[3]=8'h00; ecout[3]=1'b1; name[3]="wrap";
    va[4]=8'hFF; vb[4]=8'hFF; vc[4]=1'b1; esum[4]=8'hFF; ecout[4]=1'b1; name[4]="max";
    va[5]=8'h3F; vb[5]=8'h01; vc[5]=1'b0; esum[5]=8'h40; ecout[5]=1'b0; name[5]="nibble_cross";
    va[6]=8'h7F; vb[6]=8'h7F; vc[6]=1'b1; esum[6]=8'hFF; ecout[6]=1'b0; name[6]="nibble_full";
    for (int i = 0; i < 7; i++) begin
      drive(va[i], vb[i], vc[i]);
      checks++;
      if (cout !== ecout[i]) begin
        failures++;
        $display("FAIL %s_cout got=%b expected=%b", name[i], cout, ecout[i]);
      end
      checks++;
      if (sum !== esum[i]) begin
        failures++;
        $display("FAIL %s_sum got=%h expected=%h", name[i], sum, esum[i]);
      end
      $display("%-11s: %h + %h + %b -> cout=%b sum=%h", name[i], in0, in1, cin, cout, sum);
    end
  endtask

  // Seeded random vectors against a 9-bit reference sum.
  task automatic test_random();
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [8:0] ref_val;
    int unsigned seed_val;
    seed_val = $urandom(32'd20240611);
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom_range(255, 0));
      b = 8'($urandom_range(255, 0));
      c = 1'($urandom_range(1, 0));
      ref_val = 9'(a) + 9'(b) + 9'(c);
      drive(a, b, c);
      checks++;
      if (cout !== ref_val[8]) begin
        failures++;
        $display("FAIL random%0d_cout got=%b expected=%b", i, cout, ref_val[8]);
      end
      checks++;
      if (sum !== ref_val[7:0]) begin
        failures++;
        $display("FAIL random%0d_sum got=%h expected=%h", i, sum, ref_val[7:0]);
      end
      $display("random%-5d: %h + %h + %b -> cout=%b sum=%h", i, a, b, c, cout, sum);
    end
  endtask

  // Hold A5 + 5A + 1 (= 0x100) while toggling reset across several edges.
  task automatic test_reset_insensitive();
    for (int i = 0; i < 6; i++) begin
      reset = i[0] ? 1'b0 : 1'b1;
      drive(8'hA5, 8'h5A, 1'b1);
      checks++;
      if (cout !== 1'b1) begin
        failures++;
        $display("FAIL rst_toggle%0d_cout got=%b expected=%b", i, cout, 1'b1);
      end
      checks++;
      if (sum !== 8'h00) begin
        failures++;
        $display("FAIL rst_toggle%0d_sum got=%h expected=%h", i, sum, 8'h00);
      end
      $display("rst_tog%-4d: reset=%b %h + %h + %b -> cout=%b sum=%h",
               i, reset, in0, in1, cin, cout, sum);
    end
    reset = 1'b0;
  endtask

  // Back-to-back changes every cycle, alternating carry-heavy and carry-free.
  task automatic test_back_to_back();
    drive(8'h80, 8'h80, 1'b0);
    checks++;
    if ({cout, sum} !== 9'h100) begin
      failures++;
      $display("FAIL b2b0 got=%h expected=%h", {cout, sum}, 9'h100);
    end
    $display("b2b0       : %h + %h + %b -> cout=%b sum=%h", in0, in1, cin, cout, sum);
    drive(8'h0F, 8'hF0, 1'b1);
    checks++;
    if ({cout, sum} !== 9'h100) begin
      failures++;
      $display("FAIL b2b1 got=%h expected=%h", {cout, sum}, 9'h100);
    end
    $display("b2b1       : %h + %h + %b -> cout=%b sum=%h", in0, in1, cin, cout, sum);
    drive(8'h12, 8'h34, 1'b0);
    checks++;
    if ({cout, sum} !== 9'h046) begin
      failures++;
      $display("FAIL b2b2 got=%h expected=%h", {cout, sum}, 9'h046);
    end
    $display("b2b2       : %h + %h + %b -> cout=%b sum=%h", in0, in1, cin, cout, sum);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    in0      = 8'h00;
    in1      = 8'h00;
    cin      = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_reset_insensitive();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
